// File: rtl/conv_line_distributor.sv
// Convolution line distributor: fetches one IFM line and one filter row, zero-pads the
// line and streams KERNEL strided tap beats to the PE cluster, then pushes the output address.
module conv_line_distributor #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_ELEMS = 16,
  parameter int Q_IN       = 5,
  parameter int Q_W        = 8,
  parameter int KERNEL     = 3,
  parameter int STRIDE     = 3,
  parameter int PAD        = 1,
  parameter int NUM_PE     = 6,
  parameter int BRAM_LAT   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [ADDR_WIDTH-1:0]        cmd_in_addr,
  input  logic [ADDR_WIDTH-1:0]        cmd_filt_addr,
  input  logic [ADDR_WIDTH-1:0]        cmd_out_addr,
  input  logic                         flush,
  output logic                         input_bram_en,
  output logic [ADDR_WIDTH-1:0]        input_bram_addr,
  input  logic [LINE_ELEMS*Q_IN-1:0]   input_bram_rdata,
  output logic                         filter_bram_en,
  output logic [ADDR_WIDTH-1:0]        filter_bram_addr,
  input  logic [KERNEL*Q_W-1:0]        filter_bram_rdata,
  output logic                         pe_valid,
  input  logic                         pe_ready,
  output logic                         pe_first,
  output logic                         pe_last,
  output logic [NUM_PE*Q_IN-1:0]       pe_data,
  output logic [Q_W-1:0]               pe_weight,
  output logic                         agg_push,
  output logic [ADDR_WIDTH-1:0]        agg_addr,
  input  logic                         agg_full,
  output logic                         busy
);

  localparam int EXT_ELEMS = LINE_ELEMS + 2*PAD;
  localparam int TAP_W     = $clog2(KERNEL + 1);
  localparam int CNT_W     = $clog2(BRAM_LAT + 1);

  if ((NUM_PE-1)*STRIDE + KERNEL-1 > EXT_ELEMS-1) begin : g_bad_cfg
    $error("conv_line_distributor: PE window exceeds padded line");
  end

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_DISPATCH, S_PUSH} state_t;

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       in_addr_q, in_addr_d;
  logic [ADDR_WIDTH-1:0]       filt_addr_q, filt_addr_d;
  logic [ADDR_WIDTH-1:0]       out_addr_q, out_addr_d;
  logic [EXT_ELEMS*Q_IN-1:0]   ext_q, ext_d;
  logic [KERNEL*Q_W-1:0]       w_q, w_d;
  logic [TAP_W-1:0]            tap_q, tap_d;
  logic [CNT_W-1:0]            wait_q, wait_d;

  logic                        cmd_ready_q, cmd_ready_d;
  logic                        busy_q, busy_d;
  logic                        in_en_q, in_en_d;
  logic [ADDR_WIDTH-1:0]       in_bram_addr_q, in_bram_addr_d;
  logic                        flt_en_q, flt_en_d;
  logic [ADDR_WIDTH-1:0]       flt_bram_addr_q, flt_bram_addr_d;
  logic                        pe_valid_q, pe_valid_d;
  logic                        pe_first_q, pe_first_d;
  logic                        pe_last_q, pe_last_d;
  logic [NUM_PE*Q_IN-1:0]      pe_data_q, pe_data_d;
  logic [Q_W-1:0]              pe_weight_q, pe_weight_d;
  logic                        agg_push_q, agg_push_d;
  logic [ADDR_WIDTH-1:0]       agg_addr_q, agg_addr_d;

  // Next-state logic; every output register is derived from the next state so outputs stay registered.
  always_comb begin
    state_d     = state_q;
    in_addr_d   = in_addr_q;
    filt_addr_d = filt_addr_q;
    out_addr_d  = out_addr_q;
    ext_d       = ext_q;
    w_d         = w_q;
    tap_d       = tap_q;
    wait_d      = wait_q;
    agg_push_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          in_addr_d   = cmd_in_addr;
          filt_addr_d = cmd_filt_addr;
          out_addr_d  = cmd_out_addr;
          state_d     = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        wait_d  = CNT_W'(BRAM_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == CNT_W'(1)) begin
          ext_d = '0;
          for (int i = 0; i < LINE_ELEMS; i++) begin
            ext_d[(i+PAD)*Q_IN +: Q_IN] = input_bram_rdata[i*Q_IN +: Q_IN];
          end
          w_d     = filter_bram_rdata;
          tap_d   = '0;
          state_d = S_DISPATCH;
        end else begin
          wait_d = wait_q - CNT_W'(1);
        end
      end
      S_DISPATCH: begin
        if (pe_valid_q && pe_ready) begin
          if (tap_q == TAP_W'(KERNEL-1)) begin
            state_d    = S_PUSH;
            agg_push_d = !agg_full;
          end else begin
            tap_d = tap_q + TAP_W'(1);
          end
        end else begin
          tap_d = tap_q;
        end
      end
      S_PUSH: begin
        // agg_push_q high means the push went out this cycle; otherwise retry once the queue has room.
        if (agg_push_q) begin
          state_d = S_IDLE;
        end else if (!agg_full) begin
          agg_push_d = 1'b1;
        end else begin
          agg_push_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (flush && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      agg_push_d = 1'b0;
    end else begin
      agg_push_d = agg_push_d;
    end

    cmd_ready_d     = (state_d == S_IDLE);
    busy_d          = !cmd_ready_d;
    in_en_d         = (state_d == S_FETCH);
    flt_en_d        = (state_d == S_FETCH);
    in_bram_addr_d  = in_en_d ? in_addr_d : '0;
    flt_bram_addr_d = flt_en_d ? filt_addr_d : '0;
    agg_addr_d      = agg_push_d ? out_addr_d : '0;

    pe_valid_d  = 1'b0;
    pe_first_d  = 1'b0;
    pe_last_d   = 1'b0;
    pe_data_d   = '0;
    pe_weight_d = '0;
    if (state_d == S_DISPATCH) begin
      pe_valid_d  = 1'b1;
      pe_first_d  = (tap_d == TAP_W'(0));
      pe_last_d   = (tap_d == TAP_W'(KERNEL-1));
      for (int p = 0; p < NUM_PE; p++) begin
        pe_data_d[p*Q_IN +: Q_IN] = ext_d[(p*STRIDE + int'(tap_d))*Q_IN +: Q_IN];
      end
      pe_weight_d = w_d[int'(tap_d)*Q_W +: Q_W];
    end else begin
      pe_valid_d = 1'b0;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      in_addr_q       <= '0;
      filt_addr_q     <= '0;
      out_addr_q      <= '0;
      ext_q           <= '0;
      w_q             <= '0;
      tap_q           <= '0;
      wait_q          <= '0;
      cmd_ready_q     <= 1'b1;
      busy_q          <= 1'b0;
      in_en_q         <= 1'b0;
      in_bram_addr_q  <= '0;
      flt_en_q        <= 1'b0;
      flt_bram_addr_q <= '0;
      pe_valid_q      <= 1'b0;
      pe_first_q      <= 1'b0;
      pe_last_q       <= 1'b0;
      pe_data_q       <= '0;
      pe_weight_q     <= '0;
      agg_push_q      <= 1'b0;
      agg_addr_q      <= '0;
    end else begin
      state_q         <= state_d;
      in_addr_q       <= in_addr_d;
      filt_addr_q     <= filt_addr_d;
      out_addr_q      <= out_addr_d;
      ext_q           <= ext_d;
      w_q             <= w_d;
      tap_q           <= tap_d;
      wait_q          <= wait_d;
      cmd_ready_q     <= cmd_ready_d;
      busy_q          <= busy_d;
      in_en_q         <= in_en_d;
      in_bram_addr_q  <= in_bram_addr_d;
      flt_en_q        <= flt_en_d;
      flt_bram_addr_q <= flt_bram_addr_d;
      pe_valid_q      <= pe_valid_d;
      pe_first_q      <= pe_first_d;
      pe_last_q       <= pe_last_d;
      pe_data_q       <= pe_data_d;
      pe_weight_q     <= pe_weight_d;
      agg_push_q      <= agg_push_d;
      agg_addr_q      <= agg_addr_d;
    end
  end

  assign cmd_ready        = cmd_ready_q;
  assign busy             = busy_q;
  assign input_bram_en    = in_en_q;
  assign input_bram_addr  = in_bram_addr_q;
  assign filter_bram_en   = flt_en_q;
  assign filter_bram_addr = flt_bram_addr_q;
  assign pe_valid         = pe_valid_q;
  assign pe_first         = pe_first_q;
  assign pe_last          = pe_last_q;
  assign pe_data          = pe_data_q;
  assign pe_weight        = pe_weight_q;
  assign agg_push         = agg_push_q;
  assign agg_addr         = agg_addr_q;

endmodule

// File: tb/tb_conv_line_distributor.sv
// Scoreboard bench for conv_line_distributor: default instance plus a STRIDE=1/NUM_PE=16/BRAM_LAT=2 instance.
module tb_conv_line_distributor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cmd_valid, cmd_ready, flush, busy;
  logic [31:0] cmd_in_addr, cmd_filt_addr, cmd_out_addr;
  logic        input_bram_en, filter_bram_en;
  logic [31:0] input_bram_addr, filter_bram_addr;
  logic [79:0] input_bram_rdata;
  logic [23:0] filter_bram_rdata;
  logic        pe_valid, pe_ready, pe_first, pe_last, agg_push, agg_full;
  logic [29:0] pe_data;
  logic [7:0]  pe_weight;
  logic [31:0] agg_addr;

  logic        a_cmd_valid, a_cmd_ready, a_flush, a_busy;
  logic [31:0] a_cmd_in_addr, a_cmd_filt_addr, a_cmd_out_addr;
  logic        a_input_bram_en, a_filter_bram_en;
  logic [31:0] a_input_bram_addr, a_filter_bram_addr;
  logic [79:0] a_input_bram_rdata, a_s1_line;
  logic [23:0] a_filter_bram_rdata, a_s1_filt;
  logic        a_pe_valid, a_pe_ready, a_pe_first, a_pe_last, a_agg_push, a_agg_full;
  logic [79:0] a_pe_data;
  logic [7:0]  a_pe_weight;
  logic [31:0] a_agg_addr;

  conv_line_distributor dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_in_addr(cmd_in_addr), .cmd_filt_addr(cmd_filt_addr), .cmd_out_addr(cmd_out_addr),
    .flush(flush), .input_bram_en(input_bram_en), .input_bram_addr(input_bram_addr),
    .input_bram_rdata(input_bram_rdata), .filter_bram_en(filter_bram_en),
    .filter_bram_addr(filter_bram_addr), .filter_bram_rdata(filter_bram_rdata),
    .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_first(pe_first), .pe_last(pe_last),
    .pe_data(pe_data), .pe_weight(pe_weight), .agg_push(agg_push), .agg_addr(agg_addr),
    .agg_full(agg_full), .busy(busy)
  );

  conv_line_distributor #(.STRIDE(1), .NUM_PE(16), .BRAM_LAT(2)) u_alt (
    .clk(clk), .rst(rst), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
    .cmd_in_addr(a_cmd_in_addr), .cmd_filt_addr(a_cmd_filt_addr), .cmd_out_addr(a_cmd_out_addr),
    .flush(a_flush), .input_bram_en(a_input_bram_en), .input_bram_addr(a_input_bram_addr),
    .input_bram_rdata(a_input_bram_rdata), .filter_bram_en(a_filter_bram_en),
    .filter_bram_addr(a_filter_bram_addr), .filter_bram_rdata(a_filter_bram_rdata),
    .pe_valid(a_pe_valid), .pe_ready(a_pe_ready), .pe_first(a_pe_first), .pe_last(a_pe_last),
    .pe_data(a_pe_data), .pe_weight(a_pe_weight), .agg_push(a_agg_push), .agg_addr(a_agg_addr),
    .agg_full(a_agg_full), .busy(a_busy)
  );

  // Line at address a: element i = i+1+a (mod 32); filter at a: weight t = t+1+a.
  function automatic logic [79:0] mk_line(input logic [31:0] a);
    logic [79:0] r;
    for (int i = 0; i < 16; i++) r[i*5 +: 5] = 5'(i + 1 + a);
    return r;
  endfunction

  function automatic logic [23:0] mk_filt(input logic [31:0] a);
    logic [23:0] r;
    for (int t = 0; t < 3; t++) r[t*8 +: 8] = 8'(t + 1 + a);
    return r;
  endfunction

  // Padded position j (PAD=1) holds element j-1 = j+a, zero outside the line.
  function automatic logic [127:0] exp_lanes(input logic [31:0] a, input int tap, input int stride, input int npe);
    logic [127:0] r;
    int j;
    r = '0;
    for (int p = 0; p < npe; p++) begin
      j = p*stride + tap;
      r[p*5 +: 5] = (j < 1 || j >= 17) ? 5'd0 : 5'(j + a);
    end
    return r;
  endfunction

  // BRAM models: garbage whenever no read was issued, so mistimed captures show up.
  always @(posedge clk) begin
    input_bram_rdata  <= input_bram_en  ? mk_line(input_bram_addr)  : 80'({$urandom, $urandom, $urandom});
    filter_bram_rdata <= filter_bram_en ? mk_filt(filter_bram_addr) : 24'($urandom);
    a_s1_line          <= a_input_bram_en  ? mk_line(a_input_bram_addr)  : 80'({$urandom, $urandom, $urandom});
    a_s1_filt          <= a_filter_bram_en ? mk_filt(a_filter_bram_addr) : 24'($urandom);
    a_input_bram_rdata  <= a_s1_line;
    a_filter_bram_rdata <= a_s1_filt;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [29:0] data;
    logic [7:0]  w;
    logic        first;
    logic        last;
  } beat_t;

  beat_t       beat_q[$];
  logic [31:0] push_q[$];

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int          first_cyc, push_cyc, en_cyc;
  int          push_cnt = 0, beat_cnt = 0, hold_cnt = 0, en_cnt = 0;
  logic        push_rdy;
  logic [31:0] cur_ia, cur_fa;

  // Monitor: scoreboard pops on each handshake/push, stability check while stalled.
  initial begin
    logic  held, pv_prev;
    beat_t held_b, exp_b;
    logic [31:0] exp_a;
    held = 1'b0;
    pv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (pe_valid && !pv_prev) first_cyc = cyc;
      if (held && pe_valid) begin
        check_eq("hold_stable", {pe_data, pe_weight, pe_first, pe_last}, held_b);
        hold_cnt++;
      end
      held   = pe_valid && !pe_ready;
      held_b = {pe_data, pe_weight, pe_first, pe_last};
      if (pe_valid && pe_ready) begin
        beat_cnt++;
        if (beat_q.size() == 0) check_eq("beat_unexpected", 1, 0);
        else begin
          exp_b = beat_q.pop_front();
          check_eq("beat", {pe_data, pe_weight, pe_first, pe_last}, exp_b);
        end
      end
      if (input_bram_en) begin
        en_cyc = cyc;
        en_cnt++;
        check_eq("bram_rd", {input_bram_addr, filter_bram_addr, filter_bram_en}, {cur_ia, cur_fa, 1'b1});
      end
      if (agg_push) begin
        push_cyc = cyc;
        push_cnt++;
        push_rdy = cmd_ready;
        check_eq("push_while_full", agg_full, 0);
        if (push_q.size() == 0) check_eq("push_unexpected", 1, 0);
        else begin
          exp_a = push_q.pop_front();
          check_eq("agg_addr", agg_addr, exp_a);
        end
      end
      pv_prev = pe_valid;
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [31:0] ia, input logic [31:0] fa, input logic [31:0] oa, output int t_acc);
    beat_t b;
    cur_ia = ia;
    cur_fa = fa;
    cmd_valid = 1'b1;
    cmd_in_addr = ia;
    cmd_filt_addr = fa;
    cmd_out_addr = oa;
    t_acc = -1;
    for (int k = 0; k < 50 && t_acc < 0; k++) begin
      @(negedge clk);
      if (cmd_ready) t_acc = cyc;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (t_acc < 0) check_eq("cmd_timeout", 0, 1);
    else begin
      for (int t = 0; t < 3; t++) begin
        b.data  = 30'(exp_lanes(ia, t, 3, 6));
        b.w     = 8'(t + 1 + fa);
        b.first = (t == 0);
        b.last  = (t == 2);
        beat_q.push_back(b);
      end
      push_q.push_back(oa);
    end
  endtask

  task automatic wait_push(input int n_before);
    for (int k = 0; k < 60 && push_cnt == n_before; k++) begin
      @(posedge clk);
      #1;
    end
    if (push_cnt == n_before) check_eq("push_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, np, bc, hc, ec;
    int tf;
    logic got_first;
    rst = 1'b1; cmd_valid = 1'b0; flush = 1'b0; pe_ready = 1'b1; agg_full = 1'b0;
    cmd_in_addr = '0; cmd_filt_addr = '0; cmd_out_addr = '0;
    a_cmd_valid = 1'b0; a_flush = 1'b0; a_pe_ready = 1'b1; a_agg_full = 1'b0;
    a_cmd_in_addr = '0; a_cmd_filt_addr = '0; a_cmd_out_addr = '0;
    cur_ia = '0; cur_fa = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", {cmd_ready, a_cmd_ready}, 2'b11);
    check_eq("rst_outs", {busy, pe_valid, input_bram_en, filter_bram_en, agg_push, pe_first, pe_last}, 7'd0);
    check_eq("rst_data", {pe_data, pe_weight, agg_addr, input_bram_addr}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic: line i+1, filter 0x030201
    np = push_cnt; ec = en_cnt;
    send_cmd(32'd0, 32'd0, 32'h100, t);
    wait_push(np);
    check_eq("en_lat", en_cyc - t, 1);
    check_eq("en_once", en_cnt - ec, 1);
    check_eq("first_lat", first_cyc - t, 3);
    check_eq("push_lat", push_cyc - t, 6);
    check_eq("ready_at_push", push_rdy, 0);
    @(negedge clk);
    check_eq("ready_after_push", {cmd_ready, busy}, 2'b10);
    @(posedge clk); #1;

    // Different line/filter pattern
    np = push_cnt;
    send_cmd(32'd5, 32'd7, 32'h200, t);
    wait_push(np);
    check_eq("push_lat2", push_cyc - t, 6);

    // Backpressure on beat 1
    np = push_cnt; bc = beat_cnt; hc = hold_cnt;
    send_cmd(32'd9, 32'd2, 32'h300, t);
    wait_cyc(t + 4); pe_ready = 1'b0;
    wait_cyc(t + 8); pe_ready = 1'b1;
    wait_push(np);
    check_eq("bp_hold_cycles", hold_cnt - hc, 4);
    check_eq("bp_beats", beat_cnt - bc, 3);
    check_eq("bp_push_lat", push_cyc - t, 10);

    // Aggregation queue full during PUSH
    np = push_cnt;
    send_cmd(32'd1, 32'd3, 32'h400, t);
    agg_full = 1'b1;
    wait_cyc(t + 9);
    check_eq("full_no_push", push_cnt - np, 0);
    check_eq("full_ready_low", cmd_ready, 0);
    agg_full = 1'b0;
    wait_push(np);
    check_eq("full_push_after", push_cyc > t + 8, 1);
    repeat (5) @(posedge clk); #1;
    check_eq("full_push_once", push_cnt - np, 1);
    check_eq("full_ready_back", cmd_ready, 1);

    // Flush in WAIT
    np = push_cnt; bc = beat_cnt;
    send_cmd(32'd2, 32'd0, 32'h500, t);
    wait_cyc(t + 2); flush = 1'b1;
    beat_q.delete(); push_q.delete();
    wait_cyc(t + 3); flush = 1'b0;
    check_eq("flw_idle", {cmd_ready, busy, pe_valid}, 3'b100);
    repeat (8) @(posedge clk); #1;
    check_eq("flw_no_beats", beat_cnt - bc, 0);
    check_eq("flw_no_push", push_cnt - np, 0);

    // Flush after beat 1; beat 2 is accepted in the flush cycle
    np = push_cnt; bc = beat_cnt;
    send_cmd(32'd4, 32'd5, 32'h600, t);
    wait_cyc(t + 5); flush = 1'b1;
    wait_cyc(t + 6); flush = 1'b0;
    check_eq("fld_consumed", beat_q.size(), 0);
    push_q.delete();
    check_eq("fld_idle", {cmd_ready, pe_valid}, 2'b10);
    repeat (8) @(posedge clk); #1;
    check_eq("fld_beats", beat_cnt - bc, 3);
    check_eq("fld_no_push", push_cnt - np, 0);

    // Normal command after flush
    np = push_cnt;
    send_cmd(32'd6, 32'd9, 32'h700, t);
    wait_push(np);
    check_eq("post_flush_lat", push_cyc - t, 6);
    @(posedge clk); #1;

    // Reset mid-DISPATCH
    np = push_cnt;
    send_cmd(32'd3, 32'd3, 32'h800, t);
    wait_cyc(t + 4); rst = 1'b1;
    wait_cyc(t + 5); rst = 1'b0;
    beat_q.delete(); push_q.delete();
    check_eq("rst_mid_ready", {cmd_ready, busy}, 2'b10);
    check_eq("rst_mid_outs", {pe_valid, pe_first, pe_last, pe_data, pe_weight, agg_push, agg_addr, input_bram_en}, 0);
    repeat (6) @(posedge clk); #1;
    check_eq("rst_mid_no_push", push_cnt - np, 0);

    // Alternate configuration: STRIDE=1, NUM_PE=16, BRAM_LAT=2
    a_cmd_valid = 1'b1; a_cmd_in_addr = 32'd0; a_cmd_filt_addr = 32'd0; a_cmd_out_addr = 32'h900;
    t = -1;
    for (int k = 0; k < 20 && t < 0; k++) begin
      @(negedge clk);
      if (a_cmd_ready) t = cyc;
      @(posedge clk); #1;
    end
    a_cmd_valid = 1'b0;
    got_first = 1'b0;
    tf = -1;
    for (int k = 0; k < 20 && !got_first; k++) begin
      @(negedge clk);
      if (a_pe_valid) begin got_first = 1'b1; tf = cyc; end
    end
    check_eq("alt_first_seen", got_first, 1);
    check_eq("alt_first_lat", tf - t, 4);
    check_eq("alt_beat0", {a_pe_data, a_pe_weight, a_pe_first, a_pe_last}, {80'(exp_lanes(0, 0, 1, 16)), 8'd1, 2'b10});
    @(negedge clk);
    check_eq("alt_beat1", {a_pe_data, a_pe_weight}, {80'(exp_lanes(0, 1, 1, 16)), 8'd2});
    @(negedge clk);
    check_eq("alt_beat2", {a_pe_data, a_pe_weight, a_pe_first, a_pe_last}, {80'(exp_lanes(0, 2, 1, 16)), 8'd3, 2'b01});
    got_first = 1'b0;
    for (int k = 0; k < 10 && !got_first; k++) begin
      @(negedge clk);
      if (a_agg_push) got_first = 1'b1;
    end
    check_eq("alt_push", {got_first, a_agg_addr}, {1'b1, 32'h900});

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
